cp_inst_fetch: RTL and testbench

CP_INST_FETCH -- requirements
Module: cp_inst_fetch

---
 rtl/cp_pkg.sv | 14 +
 rtl/cp_fetch_fifo.sv | 88 ++++++++
 rtl/cp_inst_fetch.sv | 137 +++++++++++++
 tb/tb_cp_inst_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared definitions for the CP instruction-fetch path: fetch FSM encoding and
// prefetch buffer sizing.
package cp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned FETCH_FIFO_CNT_W = $clog2(FETCH_FIFO_DEPTH + 1);

endpackage

// File: rtl/cp_fetch_fifo.sv
// Two-entry instruction buffer with a flopped head slot, so the decoder-facing
// valid/data/pc come straight from registers. Flush has priority over push/pop.
module cp_fetch_fifo
  import cp_pkg::*;
#(
  parameter int DATA_W = 56,
  parameter int PC_W   = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  logic [DATA_W-1:0]           i_push_data,
  input  logic [PC_W-1:0]             i_push_pc,
  input  logic                        i_pop,
  output logic                        o_head_vld,
  output logic [DATA_W-1:0]           o_head_data,
  output logic [PC_W-1:0]             o_head_pc,
  output logic [FETCH_FIFO_CNT_W-1:0] o_count
);

  logic              r_head_vld;
  logic [DATA_W-1:0] r_head_data;
  logic [PC_W-1:0]   r_head_pc;
  logic              r_tail_vld;
  logic [DATA_W-1:0] r_tail_data;
  logic [PC_W-1:0]   r_tail_pc;
  logic              w_pop;

  assign w_pop = i_pop & r_head_vld;

  // The caller never pushes into a full buffer unless it pops in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data slots are reset too, because the head drives inst_data and
    // that output must read zero while reset is held.
    if (!rst_n) begin
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_pc   <= '0;
      r_tail_vld  <= 1'b0;
      r_tail_data <= '0;
      r_tail_pc   <= '0;
    end else if (i_flush) begin
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every slot sees pre-edge values when
      // the head and tail shift in the same cycle.
      case ({i_push, w_pop})
        2'b01: begin
          r_head_vld  <= r_tail_vld;
          r_head_data <= r_tail_data;
          r_head_pc   <= r_tail_pc;
          r_tail_vld  <= 1'b0;
        end
        2'b10: begin
          if (!r_head_vld) begin
            r_head_vld  <= 1'b1;
            r_head_data <= i_push_data;
            r_head_pc   <= i_push_pc;
          end else begin
            r_tail_vld  <= 1'b1;
            r_tail_data <= i_push_data;
            r_tail_pc   <= i_push_pc;
          end
        end
        2'b11: begin
          if (r_tail_vld) begin
            r_head_data <= r_tail_data;
            r_head_pc   <= r_tail_pc;
            r_tail_data <= i_push_data;
            r_tail_pc   <= i_push_pc;
          end else begin
            r_head_data <= i_push_data;
            r_head_pc   <= i_push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head_vld  = r_head_vld;
  assign o_head_data = r_head_data;
  assign o_head_pc   = r_head_pc;
  assign o_count     = FETCH_FIFO_CNT_W'(r_head_vld) + FETCH_FIFO_CNT_W'(r_tail_vld);

endmodule

// File: rtl/cp_inst_fetch.sv
// CP instruction fetch: walks PC from start_addr to end_addr through a 1-cycle
// synchronous instruction memory and streams words to the decoder.
module cp_inst_fetch
  import cp_pkg::*;
#(
  parameter int CP_I_WIDTH      = 56,
  parameter int IMEM_ADDR_WIDTH = 9
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic                       start,
  input  logic [IMEM_ADDR_WIDTH-1:0] start_addr,
  input  logic [IMEM_ADDR_WIDTH-1:0] end_addr,
  input  logic                       abort,
  input  logic                       jump_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] jump_addr,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_a,
  input  logic [CP_I_WIDTH-1:0]      imem_out_a,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [CP_I_WIDTH-1:0]      inst_data,
  output logic [IMEM_ADDR_WIDTH-1:0] inst_pc,
  output logic                       busy,
  output logic                       done
);

  fetch_state_e                 r_state;
  fetch_state_e                 w_state_nxt;
  logic [IMEM_ADDR_WIDTH-1:0]   r_pc;
  logic [IMEM_ADDR_WIDTH-1:0]   r_end_addr;
  logic                         r_infl_vld;
  logic [IMEM_ADDR_WIDTH-1:0]   r_infl_pc;

  logic                         w_xfer;
  logic                         w_flush;
  logic                         w_issue;
  logic                         w_load_start;
  logic                         w_load_jump;
  logic                         w_done;
  logic                         w_room;
  logic [FETCH_FIFO_CNT_W-1:0]  w_fifo_cnt;
  logic [FETCH_FIFO_CNT_W:0]    w_outstanding;
  logic [FETCH_FIFO_CNT_W:0]    w_limit;

  assign w_xfer = inst_valid & inst_ready;

  // Buffered + in-flight words, less the one leaving now, must stay below depth.
  assign w_outstanding = {1'b0, w_fifo_cnt} + {{FETCH_FIFO_CNT_W{1'b0}}, r_infl_vld};
  assign w_limit       = (FETCH_FIFO_CNT_W + 1)'(FETCH_FIFO_DEPTH)
                       + {{FETCH_FIFO_CNT_W{1'b0}}, w_xfer};
  assign w_room        = (w_outstanding < w_limit);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_load_start = 1'b0;
    w_load_jump  = 1'b0;
    w_done       = 1'b0;
    w_flush      = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_flush     = 1'b1;
    end else if (jump_valid && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_RUN;
      w_flush     = 1'b1;
      w_load_jump = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_load_start = 1'b1;
            w_state_nxt  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_room) begin
            w_issue = 1'b1;
            if (r_pc == r_end_addr) w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((w_fifo_cnt == '0) && !r_infl_vld) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A flush never coincides with an issue, so the in-flight tag simply follows it.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_pc       <= '0;
      r_end_addr <= '0;
      r_infl_vld <= 1'b0;
      r_infl_pc  <= '0;
    end else begin
      if (w_load_start)     r_pc <= start_addr;
      else if (w_load_jump) r_pc <= jump_addr;
      else if (w_issue)     r_pc <= r_pc + 1'b1;
      if (w_load_start) r_end_addr <= end_addr;
      r_infl_vld <= w_issue;
      if (w_issue) r_infl_pc <= r_pc;
    end
  end

  cp_fetch_fifo #(
    .DATA_W (CP_I_WIDTH),
    .PC_W   (IMEM_ADDR_WIDTH)
  ) u_fifo (
    .clk         (clock),
    .rst_n       (nreset),
    .i_flush     (w_flush),
    .i_push      (r_infl_vld),
    .i_push_data (imem_out_a),
    .i_push_pc   (r_infl_pc),
    .i_pop       (inst_ready),
    .o_head_vld  (inst_valid),
    .o_head_data (inst_data),
    .o_head_pc   (inst_pc),
    .o_count     (w_fifo_cnt)
  );

  assign imem_addr_a = r_pc;
  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;

endmodule

// File: tb/tb_cp_inst_fetch.sv
// Scoreboard bench for cp_inst_fetch: expected PCs are queued at start/jump and
// popped on every decoder transfer; memory returns word[i] = i.
module tb_cp_inst_fetch;

  localparam int IW = 56;
  localparam int AW = 9;

  logic          clock      = 1'b0;
  logic          nreset     = 1'b0;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          jump_valid = 1'b0;
  logic          inst_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr   = '0;
  logic [AW-1:0] jump_addr  = '0;
  logic [AW-1:0] imem_addr_a;
  logic [IW-1:0] imem_out_a;
  logic          inst_valid;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          busy;
  logic          done;

  int            n_checks   = 0;
  int            n_fail     = 0;
  int            done_cnt   = 0;
  int            xfer_cnt   = 0;
  int            cyc        = 0;
  int            ready_mode = 0;
  logic [AW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_pc    = '0;
  logic [IW-1:0] prev_data  = '0;

  always #5 clock = ~clock;

  cp_inst_fetch #(
    .CP_I_WIDTH      (IW),
    .IMEM_ADDR_WIDTH (AW)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .start       (start),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .abort       (abort),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .imem_addr_a (imem_addr_a),
    .imem_out_a  (imem_out_a),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return IW'(a);
  endfunction

  always @(posedge clock) imem_out_a <= word(imem_addr_a);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, done pulses.
  always @(negedge clock) begin
    logic [AW-1:0] e;
    #1;
    if (!nreset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && inst_valid) begin
        check("hold_pc", 64'(inst_pc), 64'(prev_pc));
        check("hold_data", 64'(inst_data), 64'(prev_data));
      end
      if (inst_valid && inst_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_xfer", 64'(inst_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", 64'(inst_pc), 64'(e));
          check("xfer_data", 64'(inst_data), 64'(word(e)));
        end
      end
      if (done) done_cnt++;
      prev_stall = inst_valid && !inst_ready;
      prev_pc    = inst_pc;
      prev_data  = inst_data;
    end
  end

  task automatic tick();
    @(negedge clock);
    start      = 1'b0;
    abort      = 1'b0;
    jump_valid = 1'b0;
    case (ready_mode)
      0:       inst_ready = 1'b1;
      1:       inst_ready = (cyc % 3 == 0);
      default: inst_ready = 1'b0;
    endcase
    cyc++;
  endtask

  task automatic push_range(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a = s;
    for (int i = 0; i < (1 << AW); i++) begin
      exp_q.push_back(a);
      if (a == e) break;
      a = a + 1'b1;
    end
  endtask

  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] e);
    tick();
    done_cnt   = 0;
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    push_range(s, e);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while ((done_cnt == 0 || exp_q.size() != 0) && n < max_cyc) begin
      tick();
      #2;
      n++;
    end
    check({tag, "_finished"}, 64'(n < max_cyc), 64'(1));
    repeat (4) tick();
    #2;
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    check("rst_valid", 64'(inst_valid), 64'(0));
    check("rst_data", 64'(inst_data), 64'(0));
    check("rst_pc", 64'(inst_pc), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_addr", 64'(imem_addr_a), 64'(0));
    tick();
    tick();
    nreset = 1'b1;
    tick();

    // Basic run with exact latency and done timing.
    ready_mode = 0;
    cyc = 0;
    launch(9'h010, 9'h013);
    for (int k = 1; k <= 8; k++) begin
      tick();
      #2;
      check($sformatf("t1_valid_k%0d", k), 64'(inst_valid), 64'(k >= 3 && k <= 6));
      check($sformatf("t1_done_k%0d", k), 64'(done), 64'(k == 7));
    end
    wait_done("t1", 20);

    // Decoder stalls 1,0,0,1,...
    ready_mode = 1;
    cyc = 0;
    launch(9'h010, 9'h013);
    wait_done("t2", 60);

    // Address wrap.
    ready_mode = 0;
    launch(9'h1FE, 9'h001);
    wait_done("t3", 20);

    // Jump after the second transfer.
    ready_mode = 0;
    xfer_cnt = 0;
    launch(9'h000, 9'h0FF);
    n = 0;
    while (xfer_cnt < 2 && n < 20) begin
      tick();
      #2;
      n++;
    end
    check("t4_two_xfers", 64'(xfer_cnt), 64'(2));
    ready_mode = 2;
    tick();
    jump_valid = 1'b1;
    jump_addr  = 9'h100;
    exp_q.delete();
    push_range(9'h100, 9'h0FF);
    ready_mode = 0;
    tick();
    #2;
    check("t4_flush_valid", 64'(inst_valid), 64'(0));
    wait_done("t4", 600);

    // Abort together with jump.
    ready_mode = 0;
    launch(9'h020, 9'h02F);
    repeat (5) tick();
    ready_mode = 2;
    tick();
    abort      = 1'b1;
    jump_valid = 1'b1;
    jump_addr  = 9'h1A0;
    exp_q.delete();
    ready_mode = 0;
    tick();
    #2;
    check("t5_valid", 64'(inst_valid), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    repeat (6) tick();
    #2;
    check("t5_no_done", 64'(done_cnt), 64'(0));
    check("t5_still_idle", 64'(inst_valid), 64'(0));
    launch(9'h030, 9'h032);
    wait_done("t5", 20);

    // Asynchronous reset with the buffer full, then a single-word run.
    ready_mode = 2;
    launch(9'h040, 9'h04F);
    repeat (6) tick();
    #2;
    check("t6_full_valid", 64'(inst_valid), 64'(1));
    #1;
    nreset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(inst_valid), 64'(0));
    check("t6_rst_data", 64'(inst_data), 64'(0));
    check("t6_rst_pc", 64'(inst_pc), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_done", 64'(done), 64'(0));
    check("t6_rst_addr", 64'(imem_addr_a), 64'(0));
    exp_q.delete();
    tick();
    tick();
    nreset = 1'b1;
    ready_mode = 0;
    repeat (4) tick();
    #2;
    check("t6_post_valid", 64'(inst_valid), 64'(0));
    check("t6_post_busy", 64'(busy), 64'(0));
    xfer_cnt = 0;
    launch(9'h005, 9'h005);
    wait_done("t6", 20);
    check("t6_one_xfer", 64'(xfer_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
